// File: rtl/rle_pkg.sv
// ----------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the run-length encoder and its downstream packer:
// block geometry, FSM state encoding, the end-of-block value and the packed
// (run, value, last) pair that travels between the stages.
// No ports (package).
// ----------------------------------------------------------------------------
package rle_pkg;

  localparam int N      = 8;                 // coefficients per block
  localparam int COEF_W = 12;                // signed DCT coefficient width
  localparam int RUN_W  = $clog2(N + 1);     // run counter must hold 0..N
  localparam int IDX_W  = $clog2(N);         // scan index 0..N-1

  // An EOB pair carries a zero value; real pairs never do.
  localparam logic signed [COEF_W-1:0] EOB_VALUE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [RUN_W-1:0]         run;
    logic signed [COEF_W-1:0] value;
    logic                     last;
  } rle_pair_t;

endpackage

// File: rtl/rle_encoder_if.sv
// ----------------------------------------------------------------------------
// rle_encoder_if
// Bundles the block input handshake (in_valid/in_ready + coef0..coef7) and
// the pair output handshake (out_valid/out_ready + run/value/last).
//   master : the side that supplies blocks and consumes pairs
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface rle_encoder_if;
  import rle_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] coef0;
  logic signed [COEF_W-1:0] coef1;
  logic signed [COEF_W-1:0] coef2;
  logic signed [COEF_W-1:0] coef3;
  logic signed [COEF_W-1:0] coef4;
  logic signed [COEF_W-1:0] coef5;
  logic signed [COEF_W-1:0] coef6;
  logic signed [COEF_W-1:0] coef7;

  logic                     out_valid;
  logic                     out_ready;
  logic [RUN_W-1:0]         out_run;
  logic signed [COEF_W-1:0] out_value;
  logic                     out_last;

  modport master (
    output in_valid, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
    output out_ready,
    input  in_ready, out_valid, out_run, out_value, out_last
  );

  modport slave (
    input  in_valid, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
    input  out_ready,
    output in_ready, out_valid, out_run, out_value, out_last
  );

endinterface

// File: rtl/rle_out_slot.sv
// ----------------------------------------------------------------------------
// rle_out_slot
// Single-entry registered valid/ready output stage.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : write i_pair into the slot (only asserted when slot is free)
//   i_pair     : pair to store
//   i_ready    : downstream accepts the current pair
//   o_valid    : slot holds a pair
//   o_pair     : stored pair; held stable while o_valid && !i_ready
// ----------------------------------------------------------------------------
module rle_out_slot
  import rle_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_load,
  input  rle_pair_t i_pair,
  input  logic      i_ready,
  output logic      o_valid,
  output rle_pair_t o_pair
);

  logic      r_valid;
  rle_pair_t r_pair;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pair  <= '0;
    end else if (i_load) begin
      // A load in the same cycle as a handshake replaces the pair, so the
      // valid flag stays up with no bubble.
      r_valid <= 1'b1;
      r_pair  <= i_pair;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pair  = r_pair;

endmodule

// File: rtl/rle_encoder.sv
// ----------------------------------------------------------------------------
// rle_encoder
// Latches one block of N signed DCT coefficients, scans them in index order
// and emits (zero-run, value) pairs; trailing zeros close with an EOB pair.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : rle_encoder_if.slave
//            in_valid/in_ready/coef0..7 : block input handshake
//            out_valid/out_ready/out_run/out_value/out_last : pair output
// ----------------------------------------------------------------------------
module rle_encoder
  import rle_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  rle_encoder_if.slave bus
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IDX_W-1:0]         r_idx;
  logic [RUN_W-1:0]         r_run;
  logic signed [COEF_W-1:0] r_coef [N];
  logic signed [COEF_W-1:0] w_coef_in [N];

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_out_valid;
  rle_pair_t                w_out_pair;
  logic                     w_slot_free;
  logic                     w_examine;
  logic signed [COEF_W-1:0] w_cur;
  logic                     w_cur_zero;
  logic                     w_at_end;
  logic                     w_load;
  rle_pair_t                w_pair;

  assign w_coef_in[0] = bus.coef0;
  assign w_coef_in[1] = bus.coef1;
  assign w_coef_in[2] = bus.coef2;
  assign w_coef_in[3] = bus.coef3;
  assign w_coef_in[4] = bus.coef4;
  assign w_coef_in[5] = bus.coef5;
  assign w_coef_in[6] = bus.coef6;
  assign w_coef_in[7] = bus.coef7;

  assign w_accept    = w_in_ready && bus.in_valid;
  // The scan only advances when the slot can take a pair this cycle, so a
  // stalled slot freezes idx/run and no pair is lost.
  assign w_slot_free = !w_out_valid || bus.out_ready;
  assign w_examine   = (r_state == SCAN) && w_slot_free;
  assign w_cur       = r_coef[r_idx];
  assign w_cur_zero  = (w_cur == '0);
  assign w_at_end    = (r_idx == IDX_W'(N - 1));
  assign w_load      = w_examine && (!w_cur_zero || w_at_end);

  // A zero at the last index closes the block as EOB, counting itself.
  assign w_pair.run   = w_cur_zero ? RUN_W'(r_run + 1'b1) : r_run;
  assign w_pair.value = w_cur_zero ? EOB_VALUE : w_cur;
  assign w_pair.last  = w_at_end;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)         w_state_next = SCAN;
      SCAN:    if (w_examine && w_at_end) w_state_next = IDLE;
      default:                            w_state_next = IDLE;
    endcase
  end

  // FSM: outputs (state only, no combinational path from in_valid/out_ready)
  always_comb begin
    w_in_ready = (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_run <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_run <= '0;
    end else if (w_examine) begin
      r_idx <= w_at_end ? '0 : IDX_W'(r_idx + 1'b1);
      r_run <= (w_cur_zero && !w_at_end) ? RUN_W'(r_run + 1'b1) : '0;
    end
  end

  // Coefficient latch: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < N; i++) r_coef[i] <= w_coef_in[i];
    end
  end

  rle_out_slot u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_pair  (w_pair),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_pair  (w_out_pair)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_run   = w_out_pair.run;
  assign bus.out_value = w_out_pair.value;
  assign bus.out_last  = w_out_pair.last;

endmodule

// File: tb/tb_rle_encoder.sv
// ----------------------------------------------------------------------------
// tb_rle_encoder
// Directed blocks with hand-computed pair lists. The driver pushes each
// block's expected pairs into a queue; a negedge monitor pops and compares on
// every output handshake and checks hold stability under backpressure.
// ----------------------------------------------------------------------------
module tb_rle_encoder;
  import rle_pkg::*;

  typedef struct {
    int run;
    int value;
    int last;
  } exp_t;

  logic clk;
  logic rst_n;
  rle_encoder_if bus ();

  rle_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  int   n_last   = 0;
  exp_t exp_q[$];
  bit   rand_on  = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int run, input int value, input int last);
    exp_t e;
    e.run = run; e.value = value; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic set_coefs(input int c [8]);
    bus.coef0 = COEF_W'(c[0]); bus.coef1 = COEF_W'(c[1]);
    bus.coef2 = COEF_W'(c[2]); bus.coef3 = COEF_W'(c[3]);
    bus.coef4 = COEF_W'(c[4]); bus.coef5 = COEF_W'(c[5]);
    bus.coef6 = COEF_W'(c[6]); bus.coef7 = COEF_W'(c[7]);
  endtask

  // Waits for an IDLE cycle, presents the block and returns the time of the
  // accepting edge. in_valid is only raised right before that edge.
  task automatic send_block(input int c [8], input bit hold_valid, output time t_acc);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.in_ready && guard < 200);
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    set_coefs(c);
    bus.in_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    $display("block accepted t=%0t coefs %0d %0d %0d %0d %0d %0d %0d %0d",
             t_acc, c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7]);
    #1;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  // Cycle offset of the current negedge relative to the accept edge T:
  // the period right after edge T is cycle T+1.
  function automatic int offset_of(input time t_acc);
    return int'(($time - t_acc + 5) / 10);
  endfunction

  task automatic wait_valid(input string name, input time t_acc, input int exp_off);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 40);
    check({name, "_valid_seen"}, int'(bus.out_valid), 1);
    check({name, "_latency"}, offset_of(t_acc), exp_off);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_q.size() != 0 || !bus.in_ready || bus.out_valid) && guard < 200);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor / scoreboard
  bit   stall_prev = 1'b0;
  int   held_run, held_val, held_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      int   got_val;
      exp_t e;
      got_val = $signed(bus.out_value);
      if (stall_prev) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_run",   int'(bus.out_run), held_run);
        check("hold_value", got_val, held_val);
        check("hold_last",  int'(bus.out_last), held_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        if (bus.out_last) n_last++;
        $display("pair run=%0d value=%0d last=%0d", bus.out_run, got_val, bus.out_last);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pair: got (%0d,%0d,%0d) expected none",
                   bus.out_run, got_val, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          check("pair_run",   int'(bus.out_run), e.run);
          check("pair_value", got_val, e.value);
          check("pair_last",  int'(bus.out_last), e.last);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_run   = int'(bus.out_run);
      held_val   = got_val;
      held_last  = int'(bus.out_last);
    end
  end

  initial begin
    int  blk [8];
    time t_acc;
    int  hs0;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    blk = '{0, 0, 0, 0, 0, 0, 0, 0};
    set_coefs(blk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_run",   int'(bus.out_run), 0);
    check("rst_out_value", int'(bus.out_value), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    rst_n = 1'b1;

    // Mixed block: first pair in cycle T+2, in_ready back in cycle T+9.
    blk = '{25, 0, 0, -3, 0, 0, 0, 0};
    push_exp(0, 25, 0); push_exp(2, -3, 0); push_exp(4, 0, 1);
    send_block(blk, 1'b0, t_acc);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_valid_T1", int'(bus.out_valid), 0);
      if (k == 2) check("t1_valid_T2", int'(bus.out_valid), 1);
      if (k == 8) check("t1_in_ready_T8", int'(bus.in_ready), 0);
      if (k == 9) check("t1_in_ready_T9", int'(bus.in_ready), 1);
    end

    // All-zero block: single EOB (8,0,1), first valid at T+9.
    blk = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_exp(8, 0, 1);
    send_block(blk, 1'b0, t_acc);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) check("t2_valid_T8", int'(bus.out_valid), 0);
      if (k == 9) check("t2_valid_T9", int'(bus.out_valid), 1);
    end

    // Dense block: eight run-0 pairs, no EOB.
    blk = '{1, 2, 3, 4, 5, 6, 7, -8};
    for (int k = 1; k <= 7; k++) push_exp(0, k, 0);
    push_exp(0, -8, 1);
    send_block(blk, 1'b0, t_acc);

    // Index-7 value held under 3 cycles of backpressure.
    blk = '{0, 0, 0, 0, 0, 0, 0, 5};
    push_exp(7, 5, 1);
    send_block(blk, 1'b0, t_acc);
    bus.out_ready = 1'b0;
    hs0 = n_hs;
    wait_valid("t4", t_acc, 9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_4th_cycle", int'(bus.out_valid), 1);
    @(negedge clk);
    check("t4_valid_after_hs", int'(bus.out_valid), 0);
    check("t4_handshakes", n_hs - hs0, 1);

    // Back-to-back blocks, in_valid held, random out_ready.
    push_exp(1, 7, 0); push_exp(2, -1, 0); push_exp(3, 0, 1);
    push_exp(0, -2048, 0); push_exp(6, 2047, 1);
    push_exp(8, 0, 1);
    push_exp(0, 3, 0); push_exp(7, 0, 1);
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        blk = '{0, 7, 0, 0, -1, 0, 0, 0};
        send_block(blk, 1'b1, t_acc);
        blk = '{-2048, 0, 0, 0, 0, 0, 0, 2047};
        send_block(blk, 1'b1, t_acc);
        blk = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk, 1'b1, t_acc);
        blk = '{3, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk, 1'b0, t_acc);
        rand_on = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    drain("t5");

    // Reset during SCAN at idx=4 discards the block.
    blk = '{0, 0, 0, 0, 0, 0, 0, 9};
    send_block(blk, 1'b0, t_acc);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", int'(bus.out_valid), 0);
    check("t6_rst_in_ready",  int'(bus.in_ready), 1);

    blk = '{0, 0, 0, 6, 0, 0, 0, 0};
    push_exp(3, 6, 0); push_exp(4, 0, 1);
    send_block(blk, 1'b0, t_acc);
    wait_valid("t6", t_acc, 5);
    drain("t6");

    check("last_count", n_last, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
